// File: rtl/digi_pkg.sv
// Shared constants for the digi_scan 7-segment display controller:
// register addresses, CTRL field positions and the all-off bus value.
package digi_pkg;

  localparam logic DIGI_ADDR_VALUE = 1'b0;
  localparam logic DIGI_ADDR_CTRL  = 1'b1;

  localparam int DIGI_VALUE_W    = 16;
  localparam int DIGI_CTRL_W     = 9;
  localparam int DIGI_CTRL_EN_LSB = 0;
  localparam int DIGI_CTRL_DP_LSB = 4;
  localparam int DIGI_CTRL_LZS    = 8;

  localparam logic [11:0] DIGI_OFF = 12'hFFF;

endpackage

// File: rtl/digi_hex_decoder.sv
// Nibble to 7-segment pattern (gfedcba, active-high) for hex digits 0..F.
module digi_hex_decoder (
  input  logic [3:0] iNibble,
  output logic [6:0] oSeg
);

  always_comb begin
    oSeg = 7'h00;
    unique case (iNibble)
      4'h0: oSeg = 7'h3F;
      4'h1: oSeg = 7'h06;
      4'h2: oSeg = 7'h5B;
      4'h3: oSeg = 7'h4F;
      4'h4: oSeg = 7'h66;
      4'h5: oSeg = 7'h6D;
      4'h6: oSeg = 7'h7D;
      4'h7: oSeg = 7'h07;
      4'h8: oSeg = 7'h7F;
      4'h9: oSeg = 7'h6F;
      4'hA: oSeg = 7'h77;
      4'hB: oSeg = 7'h7C;
      4'hC: oSeg = 7'h39;
      4'hD: oSeg = 7'h5E;
      4'hE: oSeg = 7'h79;
      4'hF: oSeg = 7'h71;
      default: oSeg = 7'h00;
    endcase
  end

endmodule

// File: rtl/digi_scan.sv
// Memory-mapped 4-digit 7-segment controller: VALUE/CTRL registers, digit
// time-multiplexing with a blank lead-in per slot, registered display bus.
module digi_scan
  import digi_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int BLANK = 16
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iWrEn,
  input  logic        iAddr,
  input  logic [31:0] iWrData,
  output logic [31:0] oRdData,
  output logic [11:0] oDigi
);

  localparam int CNT_W = $clog2(DIV);

  logic [DIGI_VALUE_W-1:0] value_q, value_d;
  logic [DIGI_CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [CNT_W-1:0]        slot_q, slot_d;
  logic [1:0]              digit_q, digit_d;
  logic [11:0]             digi_q, digi_d;

  logic       slot_last;
  logic       blank;
  logic       enabled;
  logic       suppressed;
  logic [3:0] nibble;
  logic [6:0] seg;
  logic       unused_wr;

  assign unused_wr = ^iWrData[31:DIGI_VALUE_W];

  digi_hex_decoder u_hex (
    .iNibble (nibble),
    .oSeg    (seg)
  );

  assign oRdData = (iAddr == DIGI_ADDR_CTRL) ? {{(32-DIGI_CTRL_W){1'b0}}, ctrl_q}
                                             : {{(32-DIGI_VALUE_W){1'b0}}, value_q};
  assign oDigi   = digi_q;

  always_comb begin
    value_d   = value_q;
    ctrl_d    = ctrl_q;
    slot_d    = slot_q;
    digit_d   = digit_q;
    digi_d    = DIGI_OFF;

    if (iWrEn) begin
      if (iAddr == DIGI_ADDR_CTRL) ctrl_d  = iWrData[DIGI_CTRL_W-1:0];
      else                         value_d = iWrData[DIGI_VALUE_W-1:0];
    end

    slot_last = (slot_q == CNT_W'(DIV - 1));
    if (slot_last) begin
      slot_d  = '0;
      digit_d = digit_q + 2'd1;
    end else begin
      slot_d  = slot_q + CNT_W'(1);
    end

    nibble  = value_q[digit_q*4 +: 4];
    blank   = (slot_q < CNT_W'(BLANK));
    enabled = ctrl_q[DIGI_CTRL_EN_LSB + digit_q];

    // A digit is a leading zero only if it and every more significant nibble are zero.
    suppressed = 1'b0;
    if (ctrl_q[DIGI_CTRL_LZS]) begin
      unique case (digit_q)
        2'd1:    suppressed = (value_q[15:4]  == '0);
        2'd2:    suppressed = (value_q[15:8]  == '0);
        2'd3:    suppressed = (value_q[15:12] == '0);
        default: suppressed = 1'b0;
      endcase
    end

    if (!blank && enabled && !suppressed) begin
      digi_d = {~(4'b0001 << digit_q), ~ctrl_q[DIGI_CTRL_DP_LSB + digit_q], ~seg};
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      value_q <= '0;
      ctrl_q  <= '0;
      slot_q  <= '0;
      digit_q <= '0;
      digi_q  <= DIGI_OFF;
    end else begin
      value_q <= value_d;
      ctrl_q  <= ctrl_d;
      slot_q  <= slot_d;
      digit_q <= digit_d;
      digi_q  <= digi_d;
    end
  end

endmodule

// File: tb/tb_digi_scan.sv
// Directed self-checking bench for digi_scan with DIV=8, BLANK=2.
module tb_digi_scan;

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b0;
  logic        iWrEn = 1'b0;
  logic        iAddr = 1'b0;
  logic [31:0] iWrData = '0;
  logic [31:0] oRdData;
  logic [11:0] oDigi;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  digi_scan #(.DIV(8), .BLANK(2)) dut (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .iWrEn   (iWrEn),
    .iAddr   (iAddr),
    .iWrData (iWrData),
    .oRdData (oRdData),
    .oDigi   (oDigi)
  );

  always #5 iClk = ~iClk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge iClk);
    #1;
    cyc++;
  endtask

  task automatic wr(input logic addr, input logic [31:0] data);
    iAddr   = addr;
    iWrData = data;
    iWrEn   = 1'b1;
    step();
    iWrEn   = 1'b0;
  endtask

  // Advance so the next edge starts a digit-0 slot.
  task automatic sync_refresh();
    while (cyc % 32 != 0) step();
  endtask

  task automatic check_refresh(input string tag, input logic [11:0] t0, input logic [11:0] t1,
                               input logic [11:0] t2, input logic [11:0] t3);
    logic [11:0] tab [4];
    logic [11:0] exp;
    tab[0] = t0; tab[1] = t1; tab[2] = t2; tab[3] = t3;
    for (int i = 0; i < 32; i++) begin
      step();
      exp = ((i % 8) < 2) ? 12'hFFF : tab[i / 8];
      check_val($sformatf("%s_d%0d_s%0d", tag, i / 8, i % 8), {20'h0, oDigi}, {20'h0, exp});
    end
  endtask

  initial begin
    // Reset held for three edges
    iRst_n = 1'b0;
    repeat (3) step();
    check_val("rst_digi", {20'h0, oDigi}, 32'h0000_0FFF);
    iAddr = 1'b0; #1;
    check_val("rst_rd_value", oRdData, 32'h0);
    iAddr = 1'b1; #1;
    check_val("rst_rd_ctrl", oRdData, 32'h0);
    cyc = 0;
    iRst_n = 1'b1;

    // Full scan of 12AF, all digits enabled
    wr(1'b0, 32'hDEAD_12AF);
    wr(1'b1, 32'hFFFF_FE0F);
    iAddr = 1'b0; #1;
    check_val("rd_value", oRdData, 32'h0000_12AF);
    iAddr = 1'b1; #1;
    check_val("rd_ctrl", oRdData, 32'h0000_000F);
    wr(1'b1, 32'h0000_000F);
    sync_refresh();
    check_refresh("scan1", 12'hE8E, 12'hD88, 12'hBA4, 12'h7F9);
    check_refresh("scan2", 12'hE8E, 12'hD88, 12'hBA4, 12'h7F9);

    // Enables on digits 0 and 2, decimal point only on disabled digit 1
    wr(1'b1, 32'h0000_0025);
    sync_refresh();
    check_refresh("dp_en", 12'hE8E, 12'hFFF, 12'hBA4, 12'hFFF);

    // Leading-zero suppression
    wr(1'b0, 32'h0000_0030);
    wr(1'b1, 32'h0000_010F);
    sync_refresh();
    check_refresh("lzs_30", 12'hEC0, 12'hDB0, 12'hFFF, 12'hFFF);
    wr(1'b0, 32'h0000_0000);
    sync_refresh();
    check_refresh("lzs_0", 12'hEC0, 12'hFFF, 12'hFFF, 12'hFFF);
    wr(1'b0, 32'h0000_1000);
    sync_refresh();
    check_refresh("lzs_1000", 12'hEC0, 12'hDC0, 12'hBC0, 12'h7F9);

    // Write landing on the slot wrap from digit 0 to digit 1
    wr(1'b0, 32'h0000_12AF);
    wr(1'b1, 32'h0000_000F);
    sync_refresh();
    while (cyc % 32 != 7) step();
    iAddr = 1'b0; iWrData = 32'h0000_12BF; iWrEn = 1'b1; #1;
    check_val("rd_during_wr", oRdData, 32'h0000_12AF);
    step();
    iWrEn = 1'b0; #1;
    check_val("rd_after_wr", oRdData, 32'h0000_12BF);
    check_val("wrap_last_d0", {20'h0, oDigi}, 32'h0000_0E8E);
    step();
    check_val("wrap_blank0", {20'h0, oDigi}, 32'h0000_0FFF);
    step();
    check_val("wrap_blank1", {20'h0, oDigi}, 32'h0000_0FFF);
    step();
    check_val("wrap_new_d1", {20'h0, oDigi}, 32'h0000_0D83);

    // Reset mid-slot of digit 2 together with a VALUE write
    wr(1'b0, 32'h0000_12AF);
    sync_refresh();
    while (cyc % 32 != 19) step();
    check_val("mid_d2", {20'h0, oDigi}, 32'h0000_0BA4);
    iRst_n = 1'b0;
    iAddr = 1'b0; iWrData = 32'h0000_FFFF; iWrEn = 1'b1;
    step();
    iWrEn = 1'b0; #1;
    check_val("rstwr_digi", {20'h0, oDigi}, 32'h0000_0FFF);
    check_val("rstwr_rd_value", oRdData, 32'h0);
    iAddr = 1'b1; #1;
    check_val("rstwr_rd_ctrl", oRdData, 32'h0);
    cyc = 0;
    iRst_n = 1'b1;
    wr(1'b0, 32'h0000_12AF);
    check_val("restart_s0", {20'h0, oDigi}, 32'h0000_0FFF);
    wr(1'b1, 32'h0000_000F);
    check_val("restart_s1", {20'h0, oDigi}, 32'h0000_0FFF);
    for (int s = 2; s < 8; s++) begin
      step();
      check_val($sformatf("restart_d0_s%0d", s), {20'h0, oDigi}, 32'h0000_0E8E);
    end
    step();
    check_val("restart_d1_s0", {20'h0, oDigi}, 32'h0000_0FFF);
    step();
    check_val("restart_d1_s1", {20'h0, oDigi}, 32'h0000_0FFF);
    step();
    check_val("restart_d1_s2", {20'h0, oDigi}, 32'h0000_0D88);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
